// File: rtl/bus_dma_if.sv
// Memory-side bus of the DMA master: address, R/W strobe and both data directions.
// The master drives addr/rw/data_out and samples data_in; the memories do the reverse.
interface bus_dma_if;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data_out;
    logic [7:0]  data_in;

    modport master (output addr, rw, data_out, input data_in);
    modport slave  (input addr, rw, data_out, output data_in);
endinterface

// File: rtl/bus_dma_master.sv
// Byte-copy bus master: for each byte, one read bus cycle then one write bus cycle.
// Each bus cycle spans exactly one phi_0 period, bounded by falling edges of phi_0.
module bus_dma_master #(
    parameter int LEN_W       = 14,
    parameter bit ROM_PROTECT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phi_0,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    bus_dma_if.master        bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_dbg
);
    // Handshake: start is a one-clk request, taken only while busy is low (otherwise
    // dropped); every taken start produces exactly one done pulse as busy falls.
    typedef enum logic [2:0] {IDLE, ALIGN, RD, WR, FINISH} state_t;

    state_t           state, state_n;
    logic             phi_q;
    logic             phi_fall;
    logic [15:0]      s_ptr, s_ptr_n, d_ptr, d_ptr_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [7:0]       rd_buf, rd_buf_n;
    logic             busy_n, done_n, err_n;
    logic [15:0]      addr_q, addr_n;
    logic             rw_q, rw_n;
    logic [7:0]       dout_q, dout_n;

    assign phi_fall     = phi_q & ~phi_0;
    assign bus.addr     = addr_q;
    assign bus.rw       = rw_q;
    assign bus.data_out = dout_q;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            phi_q  <= 1'b0;
            s_ptr  <= '0;
            d_ptr  <= '0;
            cnt    <= '0;
            rd_buf <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            addr_q <= '0;
            rw_q   <= 1'b1;
            dout_q <= '0;
        end else begin
            state  <= state_n;
            phi_q  <= phi_0;
            s_ptr  <= s_ptr_n;
            d_ptr  <= d_ptr_n;
            cnt    <= cnt_n;
            rd_buf <= rd_buf_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
            addr_q <= addr_n;
            rw_q   <= rw_n;
            dout_q <= dout_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_ptr_n  = s_ptr;
        d_ptr_n  = d_ptr;
        cnt_n    = cnt;
        rd_buf_n = rd_buf;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = err;
        addr_n   = 16'h0000;
        rw_n     = 1'b1;
        dout_n   = 8'h00;

        case (state)
            IDLE: begin
                if (start) begin
                    s_ptr_n = src_addr;
                    d_ptr_n = dst_addr;
                    cnt_n   = len;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = (len == '0) ? FINISH : ALIGN;
                end
            end
            ALIGN: begin
                if (phi_fall) state_n = RD;
            end
            RD: begin
                if (phi_fall) begin
                    rd_buf_n = bus.data_in;
                    // The read still completes; only the write into ROM space is refused.
                    if (ROM_PROTECT && d_ptr[15]) begin
                        err_n   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        state_n = WR;
                    end
                end
            end
            WR: begin
                if (phi_fall) begin
                    s_ptr_n = s_ptr + 16'd1;
                    d_ptr_n = d_ptr + 16'd1;
                    cnt_n   = cnt - LEN_W'(1);
                    state_n = (cnt == LEN_W'(1)) ? FINISH : RD;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Bus outputs are registered from the state being entered, so they line up with it.
        case (state_n)
            RD: begin
                addr_n = s_ptr_n;
                rw_n   = 1'b1;
            end
            WR: begin
                addr_n = d_ptr_n;
                rw_n   = 1'b0;
                dout_n = rd_buf_n;
            end
            default: begin
                addr_n = 16'h0000;
                rw_n   = 1'b1;
                dout_n = 8'h00;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: SRAM/ROM memory models on the bus, a bus-cycle monitor,
// and a byte-loop reference model that predicts the bus log and SRAM contents.
module tb_bus_dma_master;
  localparam int LEN_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phi_0 = 1'b0;
  logic start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic busy, done, err;
  logic [2:0] state_dbg;

  bus_dma_if bus_i ();

  bus_dma_master #(.LEN_W(LEN_W), .ROM_PROTECT(1'b1)) dut (
    .clk(clk), .rst(rst), .phi_0(phi_0), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .bus(bus_i), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // memories: SRAM at $0000-$1FFF, ROM at $8000-$FFFF, open bus elsewhere
  logic [7:0] sram [0:8191];
  logic [7:0] ref_sram [0:8191];
  logic [7:0] rom [0:32767];

  function automatic logic [7:0] rd8(input logic [15:0] a, input bit use_ref);
    if (a[15]) return rom[a[14:0]];
    if (a < 16'h2000) return use_ref ? ref_sram[a[12:0]] : sram[a[12:0]];
    return 8'h00;
  endfunction

  // bus log entries: {rw, addr, data} with data forced to 0 for reads
  logic [24:0] act_q[$];
  logic [24:0] exp_q[$];
  int done_count = 0;
  int done_edge = 0;
  int last_fall_edge = 0;
  int phi_cnt = 0;
  logic phi_old;
  logic [24:0] cur, seg_val;
  bit seg_new = 1'b1, seg_ok = 1'b0, seg_armed = 1'b0, fall;

  // phi_0 generator (8 clk period) and bus-cycle monitor: a cycle is recorded when the
  // bus held one value for a whole phi_0 period while busy was high
  always @(negedge clk) begin
    cur = {bus_i.rw, bus_i.addr, bus_i.rw ? 8'h00 : bus_i.data_out};
    if (done === 1'b1) begin
      done_count++;
      done_edge = cyc;
    end
    phi_old = phi_0;
    phi_cnt = (phi_cnt + 1) % 8;
    phi_0 = (phi_cnt < 4);
    fall = phi_old & ~phi_0;
    if (seg_new) begin
      seg_val = cur;
      seg_ok = seg_armed & (busy === 1'b1);
      seg_new = 1'b0;
    end else begin
      seg_ok = seg_ok & (busy === 1'b1) & (cur === seg_val);
    end
    if (fall) begin
      if (seg_ok) begin
        act_q.push_back(seg_val);
        last_fall_edge = cyc + 1;
        if (!seg_val[24] && seg_val[23:8] < 16'h2000) sram[seg_val[20:8]] = seg_val[7:0];
      end
      seg_new = 1'b1;
      seg_armed = 1'b1;
    end
    bus_i.data_in = rd8(bus_i.addr, 1'b0);
  end

  // reference model: byte loop straight from the copy rules
  task automatic build_exp(input logic [15:0] s0, input logic [15:0] d0, input int n,
                           output bit exp_err);
    logic [15:0] s, d;
    logic [7:0] b;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s0 + 16'(i);
      d = d0 + 16'(i);
      exp_q.push_back({1'b1, s, 8'h00});
      b = rd8(s, 1'b1);
      if (d[15]) begin
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back({1'b0, d, b});
      if (d < 16'h2000) ref_sram[d[12:0]] = b;
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (act_q[i] !== exp_q[i]) return i;
    if (act_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int sram_diffs();
    int n = 0;
    for (int i = 0; i < 8192; i++) if (sram[i] !== ref_sram[i]) n++;
    return n;
  endfunction

  // driver: start in the high phase of phi_0, optionally poke a second start mid-transfer
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                          input int poke, output bit to);
    act_q.delete();
    done_count = 0;
    do begin @(negedge clk); #1; end while (phi_0 !== 1'b1);
    start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
    @(negedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      if (poke > 0 && k == poke) begin
        start = 1'b1; src_addr = s ^ 16'h0F0F; dst_addr = d ^ 16'h00F0; len = LEN_W'(n + 2);
      end else begin
        start = 1'b0;
      end
      if (done_count > 0) begin
        to = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic test_copy(input string name, input logic [15:0] s, input logic [15:0] d,
                           input int n, input int poke);
    bit exp_err, to;
    int idx, nd;
    build_exp(s, d, n, exp_err);
    run_xfer(s, d, n, poke, to);
    n_chk++;
    if (to) $display("FAIL %s timeout: no done within budget", name); else n_pass++;
    idx = first_diff();
    n_chk++;
    if (idx >= 0)
      $display("FAIL %s buslog: entry %0d act=%h exp=%h (act %0d entries, exp %0d)", name, idx,
               (idx < act_q.size()) ? act_q[idx] : 25'h0, (idx < exp_q.size()) ? exp_q[idx] : 25'h0,
               act_q.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (done_count !== 1) $display("FAIL %s done_pulses: act=%0d exp=1", name, done_count);
    else n_pass++;
    n_chk++;
    if (err !== exp_err) $display("FAIL %s err: act=%b exp=%b", name, err, exp_err);
    else n_pass++;
    n_chk++;
    if (done_edge !== last_fall_edge + 1)
      $display("FAIL %s done_latency: done at clk %0d, exp %0d", name, done_edge, last_fall_edge + 1);
    else n_pass++;
    nd = sram_diffs();
    n_chk++;
    if (nd !== 0) $display("FAIL %s sram: act=%0d differing bytes exp=0", name, nd);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({bus_i.addr, bus_i.rw, bus_i.data_out, busy, done, err} !== {16'h0, 1'b1, 8'h0, 3'b000})
      $display("FAIL reset_values: addr=%h rw=%b dout=%h busy=%b done=%b err=%b",
               bus_i.addr, bus_i.rw, bus_i.data_out, busy, done, err);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_rom_copy();
    test_copy("rom_copy", 16'h8000, 16'h0000, 4, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (sram[i] !== rom[i]) $display("FAIL rom_copy byte%0d: act=%h exp=%h", i, sram[i], rom[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] old0;
    old0 = sram[0];
    test_copy("wrap", 16'hFFFF, 16'h1FFE, 2, 0);
    n_chk++;
    if (sram[13'h1FFF] !== old0) $display("FAIL wrap_byte: act=%h exp=%h", sram[13'h1FFF], old0);
    else n_pass++;
  endtask

  task automatic test_rom_protect();
    int bad = 0;
    test_copy("rom_protect", 16'h0010, 16'h7FFF, 2, 0);
    foreach (act_q[i]) if (act_q[i][24] == 1'b0 && act_q[i][23:8] == 16'h8000) bad++;
    n_chk++;
    if (bad !== 0 || err !== 1'b1) $display("FAIL rom_protect_abort: writes@8000=%0d err=%b exp 0,1", bad, err);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    act_q.delete();
    done_count = 0;
    @(negedge clk); #1;
    start = 1'b1; src_addr = 16'h1234; dst_addr = 16'h0555; len = '0;
    @(negedge clk); #1;
    start = 1'b0;
    n_chk++;
    if ({busy, done} !== 2'b10) $display("FAIL zero_len_clk1: busy,done act=%b%b exp=10", busy, done);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if ({busy, done} !== 2'b01) $display("FAIL zero_len_clk2: busy,done act=%b%b exp=01", busy, done);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if ({busy, done} !== 2'b00) $display("FAIL zero_len_clk3: busy,done act=%b%b exp=00", busy, done);
    else n_pass++;
    repeat (16) @(negedge clk);
    #1;
    n_chk++;
    if (act_q.size() !== 0 || done_count !== 1)
      $display("FAIL zero_len_bus: cycles=%0d done_pulses=%0d exp 0,1", act_q.size(), done_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    test_copy("busy_start", 16'h8100, 16'h0200, 3, 20);
    test_copy("back_to_back", 16'h0200, 16'h0300, 3, 0);
  endtask

  task automatic test_data_integrity();
    sram[13'h0000] = 8'hAA; ref_sram[13'h0000] = 8'hAA;
    sram[13'h1FFF] = 8'h55; ref_sram[13'h1FFF] = 8'h55;
    test_copy("integrity_a", 16'h0000, 16'h1000, 1, 0);
    test_copy("integrity_b", 16'h1FFF, 16'h1001, 1, 0);
    n_chk++;
    if ({sram[13'h1000], sram[13'h1001]} !== 16'hAA55)
      $display("FAIL integrity_bytes: act=%h%h exp=AA55", sram[13'h1000], sram[13'h1001]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] s, d;
    for (int t = 0; t < 6; t++) begin
      s = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom_range(16'h8000, 16'hFFFF));
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h7FFA, 16'h7FFF)) : 16'($urandom_range(0, 16'h1FF0));
      test_copy("random", s, d, int'($urandom_range(1, 6)), 0);
    end
  endtask

  task automatic test_reset_mid_rd();
    bit seen = 1'b0;
    int nd;
    do begin @(negedge clk); #1; end while (phi_0 !== 1'b1);
    start = 1'b1; src_addr = 16'h0123; dst_addr = 16'h0400; len = LEN_W'(3);
    @(negedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (busy === 1'b1 && bus_i.rw === 1'b1 && bus_i.addr === 16'h0123) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    n_chk++;
    if (!seen) $display("FAIL reset_mid_rd_reach: read of 0123 not seen within budget");
    else n_pass++;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({bus_i.addr, bus_i.rw, bus_i.data_out, busy, done, err} !== {16'h0, 1'b1, 8'h0, 3'b000})
      $display("FAIL reset_mid_rd: addr=%h rw=%b dout=%h busy=%b done=%b err=%b",
               bus_i.addr, bus_i.rw, bus_i.data_out, busy, done, err);
    else n_pass++;
    done_count = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    nd = sram_diffs();
    n_chk++;
    if (done_count !== 0 || nd !== 0)
      $display("FAIL reset_mid_rd_after: done_pulses=%0d sram_diffs=%0d exp 0,0", done_count, nd);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++) begin
      sram[i] = 8'($urandom);
      ref_sram[i] = sram[i];
    end
    bus_i.data_in = 8'h00;
    test_reset();
    test_rom_copy();
    test_wrap();
    test_rom_protect();
    test_zero_len();
    test_back_to_back();
    test_data_integrity();
    test_random();
    test_reset_mid_rd();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
